// File: rtl/fcs_frame_ctrl.sv
// fcs_frame_ctrl: frames an upstream byte stream onto the serial FCS engine
// (MSB first), waits for the engine result and presents one record per frame.
// The engine is held in reset whenever the sequencer is idle.
module fcs_frame_ctrl #(
    parameter int MAX_BYTES    = 256,
    parameter int MIN_BYTES    = 1,
    parameter int LEN_W        = 9,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             fcs_rst,
    output logic             fcs_en,
    output logic             fcs_data,
    input  logic             fcs_done,
    input  logic             fcs_len_error,
    input  logic [15:0]      fcs_value,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [15:0]      result_fcs,
    output logic [LEN_W-1:0] result_len,
    output logic [2:0]       result_status
);

    localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESULT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_sr;
    logic [2:0]       r_bit_cnt;
    logic             r_have_byte;
    logic             r_last_loaded;
    logic             r_ovf;
    logic [LEN_W-1:0] r_byte_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [15:0]      r_result_fcs;
    logic [LEN_W-1:0] r_result_len;
    logic [2:0]       r_result_status;

    logic             w_accept;
    logic             w_timeout;
    logic             w_len_viol;

    assign w_accept   = s_valid & s_ready;
    assign w_timeout  = (r_to_cnt == TO_W'(DONE_TIMEOUT));
    assign w_len_viol = r_ovf | (r_byte_cnt < LEN_W'(MIN_BYTES));

    // fcs_data holds the current MSB; it stays put while the shifter is empty
    assign fcs_data      = r_sr[7];
    assign result_fcs    = r_result_fcs;
    assign result_len    = r_result_len;
    assign result_status = r_result_status;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/engine control decode from registered state only
    always_comb begin
        w_state_nxt  = r_state;
        s_ready      = 1'b0;
        fcs_rst      = 1'b0;
        fcs_en       = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                fcs_rst = 1'b1;
                if (s_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Accept while empty, or on the final bit for a gapless reload
                s_ready = !r_have_byte || ((r_bit_cnt == 3'd7) && !r_last_loaded);
                fcs_en  = r_have_byte && !r_ovf;
                if (r_have_byte && (r_bit_cnt == 3'd7) && r_last_loaded) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (fcs_done || w_timeout) begin
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shifter, byte/timeout counters and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr            <= '0;
            r_bit_cnt       <= '0;
            r_have_byte     <= 1'b0;
            r_last_loaded   <= 1'b0;
            r_ovf           <= 1'b0;
            r_byte_cnt      <= '0;
            r_to_cnt        <= '0;
            r_result_fcs    <= '0;
            r_result_len    <= '0;
            r_result_status <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        r_bit_cnt     <= '0;
                        r_have_byte   <= 1'b0;
                        r_last_loaded <= 1'b0;
                        r_ovf         <= 1'b0;
                        r_byte_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_to_cnt <= '0;
                    if (w_accept) begin
                        r_sr          <= s_data;
                        r_bit_cnt     <= '0;
                        r_have_byte   <= 1'b1;
                        r_last_loaded <= s_last;
                        // Bytes past the limit are consumed but never reach the engine
                        if (r_byte_cnt == LEN_W'(MAX_BYTES)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                        end
                    end else if (r_have_byte) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_have_byte <= 1'b0;
                        end else begin
                            r_sr      <= {r_sr[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (fcs_done) begin
                        r_result_fcs    <= fcs_value;
                        r_result_len    <= r_byte_cnt;
                        r_result_status <= {1'b0, w_len_viol, fcs_len_error};
                    end else if (w_timeout) begin
                        r_result_fcs    <= '0;
                        r_result_len    <= r_byte_cnt;
                        r_result_status <= {1'b1, w_len_viol, 1'b0};
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcs_frame_ctrl.sv
// tb_fcs_frame_ctrl: directed bench for the FCS frame sequencer.
module tb_fcs_frame_ctrl;

    localparam int MAXB = 4;
    localparam int TMO  = 64;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        fcs_rst;
    logic        fcs_en;
    logic        fcs_data;
    logic        fcs_done;
    logic        fcs_len_error;
    logic [15:0] fcs_value;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_fcs;
    logic [8:0]  result_len;
    logic [2:0]  result_status;

    int n_checks;
    int n_errors;
    int acc_cnt;
    int cyc;

    // Engine-side log: every enabled bit and the cycle it appeared in
    logic bit_q  [0:63];
    int   en_cyc [0:63];
    int   nbits;

    fcs_frame_ctrl #(
        .MAX_BYTES   (MAXB),
        .MIN_BYTES   (1),
        .LEN_W       (9),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .fcs_rst      (fcs_rst),
        .fcs_en       (fcs_en),
        .fcs_data     (fcs_data),
        .fcs_done     (fcs_done),
        .fcs_len_error(fcs_len_error),
        .fcs_value    (fcs_value),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_fcs   (result_fcs),
        .result_len   (result_len),
        .result_status(result_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Serial engine model: cleared by fcs_rst, records bits while enabled
    always @(negedge clk) begin
        if (fcs_rst) begin
            nbits <= 0;
        end else if (fcs_en && nbits < 64) begin
            bit_q[nbits]  <= fcs_data;
            en_cyc[nbits] <= cyc;
            nbits         <= nbits + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bits_word(input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n && i < 32; i++) begin
            w = {w[30:0], bit_q[i]};
        end
        return w;
    endfunction

    // Present one byte and hold it until the handshake edge has passed
    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(s_ready), 32'd1);
        if (s_ready) acc_cnt++;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(output int rv_cyc);
        int t;
        t = 0;
        while (!result_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("result_valid", 32'(result_valid), 32'd1);
        rv_cyc = cyc;
    endtask

    task automatic ack_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    int rv;
    int rv_cnt;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        acc_cnt       = 0;
        rst           = 1'b1;
        s_valid       = 1'b0;
        s_data        = 8'h00;
        s_last        = 1'b0;
        fcs_done      = 1'b0;
        fcs_len_error = 1'b0;
        fcs_value     = 16'h0000;
        result_ready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_fcs_rst", 32'(fcs_rst), 32'd1);
        chk("rst_fcs_en", 32'(fcs_en), 32'd0);
        chk("rst_fcs_data", 32'(fcs_data), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_rfcs", 32'(result_fcs), 32'd0);
        chk("rst_rlen", 32'(result_len), 32'd0);
        chk("rst_rstat", 32'(result_status), 32'd0);
        rst = 1'b0;

        // Two-byte frame, no stalls
        fcs_done  = 1'b1;
        fcs_value = 16'h1234;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b1);
        wait_result(rv);
        chk("t1_nbits", 32'(nbits), 32'd16);
        chk("t1_bits", bits_word(16), 32'h0000A53C);
        chk("t1_span", 32'(en_cyc[15] - en_cyc[0]), 32'd15);
        chk("t1_latency", 32'(rv - en_cyc[15]), 32'd2);
        chk("t1_fcs", 32'(result_fcs), 32'h1234);
        chk("t1_len", 32'(result_len), 32'd2);
        chk("t1_stat", 32'(result_status), 32'd0);
        ack_result();

        // Same frame with a 3-cycle upstream gap between the bytes
        send_byte(8'hA5, 1'b0);
        repeat (7) @(negedge clk);
        repeat (3) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        wait_result(rv);
        chk("t2_nbits", 32'(nbits), 32'd16);
        chk("t2_bits", bits_word(16), 32'h0000A53C);
        chk("t2_gap", 32'(en_cyc[8] - en_cyc[7]), 32'd4);
        chk("t2_byte0", 32'(en_cyc[7] - en_cyc[0]), 32'd7);
        chk("t2_byte1", 32'(en_cyc[15] - en_cyc[8]), 32'd7);
        chk("t2_fcs", 32'(result_fcs), 32'h1234);
        chk("t2_len", 32'(result_len), 32'd2);
        chk("t2_stat", 32'(result_status), 32'd0);
        ack_result();

        // Overflow: six bytes against a four-byte limit
        acc_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i), (i == 6));
        end
        wait_result(rv);
        chk("t3_accepted", 32'(acc_cnt), 32'd6);
        chk("t3_nbits", 32'(nbits), 32'd32);
        chk("t3_bits", bits_word(32), 32'h01020304);
        chk("t3_span", 32'(en_cyc[31] - en_cyc[0]), 32'd31);
        chk("t3_len", 32'(result_len), 32'd4);
        chk("t3_stat", 32'(result_status), 32'b010);
        ack_result();

        // Engine never completes: timeout record
        fcs_done = 1'b0;
        send_byte(8'h81, 1'b1);
        wait_result(rv);
        chk("t4_nbits", 32'(nbits), 32'd8);
        chk("t4_bits", bits_word(8), 32'h00000081);
        chk("t4_latency", 32'(rv - en_cyc[7]), 32'(TMO + 2));
        chk("t4_stat", 32'(result_status), 32'b100);
        chk("t4_fcs", 32'(result_fcs), 32'd0);
        chk("t4_len", 32'(result_len), 32'd1);
        ack_result();

        // Engine reports LenError
        fcs_done      = 1'b1;
        fcs_len_error = 1'b1;
        fcs_value     = 16'hBEEF;
        send_byte(8'h7E, 1'b1);
        wait_result(rv);
        chk("t5_latency", 32'(rv - en_cyc[7]), 32'd2);
        chk("t5_stat", 32'(result_status), 32'b001);
        chk("t5_fcs", 32'(result_fcs), 32'hBEEF);
        ack_result();
        fcs_len_error = 1'b0;
        fcs_value     = 16'h1234;

        // Reset pulse after three bits of the first byte
        send_byte(8'hF0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_fcs_rst", 32'(fcs_rst), 32'd1);
        chk("t6_fcs_en", 32'(fcs_en), 32'd0);
        chk("t6_s_ready", 32'(s_ready), 32'd0);
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (result_valid) rv_cnt++;
            @(negedge clk);
        end
        chk("t6_no_result", 32'(rv_cnt), 32'd0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b1);
        wait_result(rv);
        chk("t6_nbits", 32'(nbits), 32'd16);
        chk("t6_bits", bits_word(16), 32'h00005AC3);
        chk("t6_len", 32'(result_len), 32'd2);
        chk("t6_stat", 32'(result_status), 32'd0);
        ack_result();

        // Result backpressure, then back-to-back next frame
        fcs_value = 16'hCAFE;
        send_byte(8'h96, 1'b1);
        wait_result(rv);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t7_rvalid", 32'(result_valid), 32'd1);
            chk("t7_fcs", 32'(result_fcs), 32'hCAFE);
            chk("t7_len", 32'(result_len), 32'd1);
            chk("t7_stat", 32'(result_status), 32'd0);
            chk("t7_s_ready", 32'(s_ready), 32'd0);
            chk("t7_fcs_rst", 32'(fcs_rst), 32'd0);
        end
        result_ready = 1'b1;
        s_valid      = 1'b1;
        s_data       = 8'h3C;
        s_last       = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("t7_idle_fcs_rst", 32'(fcs_rst), 32'd1);
        chk("t7_idle_s_ready", 32'(s_ready), 32'd0);
        chk("t7_idle_rvalid", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("t7_shift_s_ready", 32'(s_ready), 32'd1);
        chk("t7_shift_fcs_rst", 32'(fcs_rst), 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t7_first_bit_en", 32'(fcs_en), 32'd1);
        wait_result(rv);
        chk("t7_nbits", 32'(nbits), 32'd8);
        chk("t7_bits", bits_word(8), 32'h0000003C);
        chk("t7_len2", 32'(result_len), 32'd1);
        ack_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fcs_frame_ctrl.md
# fcs_frame_ctrl

Frame sequencer for the 16-bit serial FCS (CRC) engine. It accepts a byte stream with valid/ready handshaking and serializes each frame MSB-first onto the engine's `en`/`data` inputs. It then waits for the engine's `done`, captures the FCS and `LenError`, and presents one result record per frame. It also owns the engine's reset, so the engine is cleared between frames.

## Interface
- `MAX_BYTES`, 256: maximum frame length; bytes beyond this are consumed but not fed to the engine.
- `MIN_BYTES`, 1: frames shorter than this are flagged.
- `LEN_W`, 9: width of byte counter and `result_len`; must satisfy 2^LEN_W > MAX_BYTES.
- `DONE_TIMEOUT`, 64: cycles allowed in WAIT_DONE before declaring engine timeout.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: upstream byte valid.
- `s_data` in 8: upstream byte.
- `s_last` in 1: byte is the last of the frame.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `fcs_rst` out 1: engine reset.
- `fcs_en` out 1: engine bit enable.
- `fcs_data` out 1: engine serial bit.
- `fcs_done` in 1: engine result ready, level or pulse.
- `fcs_len_error` in 1: engine length error, sampled with `fcs_done`.
- `fcs_value` in 16: engine FCS, sampled with `fcs_done`.
- `result_valid` out 1: result record valid.
- `result_ready` in 1: record consumed when `result_valid & result_ready`.
- `result_fcs` out 16: captured FCS.
- `result_len` out LEN_W: accepted byte count, saturating at MAX_BYTES.
- `result_status` out 3: [0] engine LenError, [1] length violation (short or overflow), [2] done timeout.

## Operation
- **States:** IDLE, SHIFT, WAIT_DONE, RESULT.
- **IDLE:** `fcs_rst`=1, `s_ready`=0. When `s_valid`=1, go to SHIFT; byte counter and flags are cleared.
- **SHIFT:** `fcs_rst`=0. The datapath is an 8-bit shift register `sr`, a 3-bit bit counter, `have_byte`, `last_loaded` and `ovf`.
  - `s_ready` = `!have_byte | (bit_cnt==7 & !last_loaded)`. This allows a gapless back-to-back load on the last bit.
  - On handshake: load `sr`, set `bit_cnt`=0, `have_byte`=1, `last_loaded`=`s_last`.
  - If the byte counter already equals MAX_BYTES, set `ovf`=1; otherwise increment the counter.
  - `fcs_en` = `have_byte & !ovf`, registered. `fcs_data` = `sr[7]`.
  - Each cycle with `have_byte`=1: shift `sr` left and increment `bit_cnt`. At `bit_cnt`==7 with no new load, clear `have_byte`.
  - After the last bit of the `last_loaded` byte, go to WAIT_DONE.
  - An upstream stall leaves `fcs_en`=0 and `fcs_data` held. The engine pauses and the bit order is unchanged.
- **WAIT_DONE:** `fcs_en`=0, `s_ready`=0, timeout counter runs.
  - On the first cycle with `fcs_done`=1, capture `fcs_value` and `fcs_len_error`, then go to RESULT.
  - After DONE_TIMEOUT cycles without `fcs_done`, set status[2], `result_fcs`=0, and go to RESULT.
- **RESULT:** `result_valid`=1. Fields are stable until the handshake, then go to IDLE.
  - status[1] = `ovf | (len < MIN_BYTES)`.
- **Reset:** state=IDLE, `fcs_rst`=1, `fcs_en`=0, `fcs_data`=0, `s_ready`=0, `result_valid`=0, `result_fcs`=0, `result_len`=0, `result_status`=0.
  - Reset mid-frame discards the partial frame. No result is emitted for it.

## Timing
- `s_valid` seen in IDLE at cycle T: SHIFT with `s_ready`=1 and `fcs_rst`=0 at T+1.
- Byte accepted at cycle N: bit7 on `fcs_data` with `fcs_en`=1 at N+1, bit0 at N+8. The next byte can be accepted at N+8, so its bit7 appears at N+9.
- An n-byte frame with no stalls gives exactly 8n contiguous `fcs_en` cycles.
- WAIT_DONE is entered the cycle after the final bit. If `fcs_done` is seen at cycle D, `result_valid` rises at D+1.
- A timeout produces `result_valid` DONE_TIMEOUT+1 cycles after WAIT_DONE entry.
- With `s_valid` and `result_ready` held high, there is a 1-cycle IDLE gap between frames. `fcs_rst` is asserted in that cycle.
- `s_ready` is decoded from registered state only. It has no combinational path from `s_valid`.

## Test plan
- **Two-byte frame, no stalls:** bytes 0xA5, 0x3C with last on the second byte; engine model returns 0x1234.
  - Required: `fcs_data` = 1010_0101_0011_1100 over 16 contiguous `fcs_en` cycles.
  - Required: `result_fcs`=0x1234, `result_len`=2, status=0.
- **Upstream stalls:** same frame with `s_valid` low for 3 cycles between the bytes.
  - Required: `fcs_en` low for exactly those gap cycles; bit sequence and result unchanged.
- **Overflow:** MAX_BYTES=4, 6-byte frame.
  - Required: 32 `fcs_en` cycles; all 6 bytes accepted; `result_len`=4, status=3'b010.
- **Timeout and LenError:** engine never asserts `fcs_done`.
  - Required: `result_valid` at WAIT_DONE entry + DONE_TIMEOUT + 1, status=3'b100, `result_fcs`=0.
  - Then with `fcs_done` and `fcs_len_error`=1: status=3'b001.
- **Reset mid-frame:** `rst` pulsed after 3 bits of the first byte.
  - Required: next cycle `fcs_rst`=1, `fcs_en`=0, `s_ready`=0, no result.
  - Required: the following frame is serialized correctly.
- **Result backpressure:** `result_ready` held low for 10 cycles.
  - Required: fields stable, `s_ready`=0, `fcs_rst`=0.
  - Required: after the handshake, one IDLE cycle, then the next frame is accepted.
